// File: rtl/label_equiv_ctrl_pkg.sv
// Shared types for the connected-component equivalence-table controller.
// Label width is fixed here so every block agrees on label_t.
package label_pkg;

  localparam int LABEL_WIDTH         = 8;
  localparam int DEFAULT_MERGE_DEPTH = 4;
  localparam int TABLE_SIZE          = 2 ** LABEL_WIDTH;

  typedef logic [LABEL_WIDTH-1:0] label_t;

  localparam label_t BG_LABEL = '0;

  typedef struct packed {
    label_t a;
    label_t b;
  } merge_req_t;

  typedef enum logic [1:0] {COLLECT, DRAIN, FLATTEN, READY} ctrl_state_e;
  typedef enum logic [1:0] {IDLE, FIND_A, FIND_B, LINK} find_state_e;

  function automatic label_t label_min(label_t x, label_t y);
    return (x < y) ? x : y;
  endfunction

  function automatic label_t label_max(label_t x, label_t y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/label_equiv_ctrl_if.sv
// Labeler / bounding-box side bus of the equivalence-table controller.
// table_release stands in for "release", which is a reserved word.
interface label_equiv_ctrl_if;

  logic             new_label_valid;
  label_pkg::label_t new_label_value;
  logic             merge_valid;
  label_pkg::label_t merge_a;
  label_pkg::label_t merge_b;
  logic             frame_end;
  logic             busy;
  logic             lookup_valid;
  label_pkg::label_t lookup_label;
  logic             resolved_valid;
  label_pkg::label_t resolved_label;
  logic             table_ready;
  logic             table_release;
  logic             overflow;

  modport master (
    output new_label_valid, new_label_value, merge_valid, merge_a, merge_b,
           frame_end, lookup_valid, lookup_label, table_release,
    input  busy, resolved_valid, resolved_label, table_ready, overflow
  );

  modport slave (
    input  new_label_valid, new_label_value, merge_valid, merge_a, merge_b,
           frame_end, lookup_valid, lookup_label, table_release,
    output busy, resolved_valid, resolved_label, table_ready, overflow
  );

endinterface

// File: rtl/merge_fifo.sv
// Synchronous FIFO of pending merge requests; one extra pointer bit
// distinguishes full from empty.
module merge_fifo
  import label_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MERGE_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  merge_req_t din,
  input  logic       pop,
  output merge_req_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  merge_req_t      mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/label_equiv_ctrl.sv
// Equivalence-table controller: collects labels and merges, links roots in
// the background, flattens the table at frame end, then serves lookups.
module label_equiv_ctrl
  import label_pkg::*;
#(
  parameter int MERGE_DEPTH = DEFAULT_MERGE_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  label_equiv_ctrl_if.slave bus
);

  label_t [TABLE_SIZE-1:0] parent;

  ctrl_state_e ctrl_q, ctrl_d;
  find_state_e find_q, find_d;
  label_t      walk_q, walk_d, b_q, b_d, ra_q, ra_d, rb_q, rb_d;
  label_t      max_label_q, flat_idx_q;
  logic        overflow_q, resolved_valid_q;
  label_t      resolved_label_q;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  merge_req_t  fifo_din, fifo_dout;
  logic        new_we, link_we, flat_we, in_collect, lookup_hit;
  label_t      walk_parent, link_addr, link_data, flat_data;

  assign in_collect  = (ctrl_q == COLLECT);
  assign new_we      = in_collect && bus.new_label_valid && (bus.new_label_value != BG_LABEL);
  assign fifo_din    = '{a: bus.merge_a, b: bus.merge_b};
  assign fifo_push   = in_collect && bus.merge_valid && !fifo_full &&
                       (bus.merge_a != bus.merge_b) &&
                       (bus.merge_a != BG_LABEL) && (bus.merge_b != BG_LABEL);
  assign walk_parent = parent[walk_q];
  assign link_addr   = label_max(ra_q, rb_q);
  assign link_data   = label_min(ra_q, rb_q);
  assign flat_data   = parent[parent[flat_idx_q]];
  assign lookup_hit  = (ctrl_q == READY) && bus.lookup_valid;

  merge_fifo #(.DEPTH(MERGE_DEPTH)) u_merge_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Later writes win, so a fresh allocation overrides a link to the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parent <= '0;
    end else begin
      if (link_we)  parent[link_addr]           <= link_data;
      if (flat_we)  parent[flat_idx_q]          <= flat_data;
      if (new_we)   parent[bus.new_label_value] <= bus.new_label_value;
    end
  end

  // NOTE: every comb output gets a default first, so no latches are inferred.
  always_comb begin : find_fsm
    find_d   = find_q;
    walk_d   = walk_q;
    b_d      = b_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    fifo_pop = 1'b0;
    link_we  = 1'b0;
    unique case (find_q)
      IDLE: begin
        if (!fifo_empty && (ctrl_q == COLLECT || ctrl_q == DRAIN)) begin
          fifo_pop = 1'b1;
          walk_d   = fifo_dout.a;
          b_d      = fifo_dout.b;
          find_d   = FIND_A;
        end
      end
      FIND_A: begin
        if (walk_parent == walk_q) begin
          ra_d   = walk_q;
          walk_d = b_q;
          find_d = FIND_B;
        end else begin
          walk_d = walk_parent;
        end
      end
      FIND_B: begin
        if (walk_parent == walk_q) begin
          rb_d   = walk_q;
          find_d = LINK;
        end else begin
          walk_d = walk_parent;
        end
      end
      LINK: begin
        link_we = (ra_q != rb_q) && (link_addr != BG_LABEL);
        find_d  = IDLE;
      end
    endcase
  end

  // Ascending flatten: parent[parent[i]] is already a root when entry i is visited.
  always_comb begin : ctrl_fsm
    ctrl_d  = ctrl_q;
    flat_we = 1'b0;
    unique case (ctrl_q)
      COLLECT: if (bus.frame_end) ctrl_d = DRAIN;
      DRAIN: begin
        if (fifo_empty && find_q == IDLE)
          ctrl_d = (max_label_q == BG_LABEL) ? READY : FLATTEN;
      end
      FLATTEN: begin
        flat_we = 1'b1;
        if (flat_idx_q == max_label_q) ctrl_d = READY;
      end
      READY: if (bus.table_release) ctrl_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q           <= COLLECT;
      find_q           <= IDLE;
      walk_q           <= BG_LABEL;
      b_q              <= BG_LABEL;
      ra_q             <= BG_LABEL;
      rb_q             <= BG_LABEL;
      max_label_q      <= BG_LABEL;
      flat_idx_q       <= BG_LABEL;
      overflow_q       <= 1'b0;
      resolved_valid_q <= 1'b0;
      resolved_label_q <= BG_LABEL;
    end else begin
      ctrl_q <= ctrl_d;
      find_q <= find_d;
      walk_q <= walk_d;
      b_q    <= b_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;

      if (new_we) max_label_q <= bus.new_label_value;
      if (in_collect && bus.new_label_valid && bus.new_label_value == BG_LABEL)
        overflow_q <= 1'b1;

      if (ctrl_q == DRAIN)        flat_idx_q <= label_t'(1);
      else if (ctrl_q == FLATTEN) flat_idx_q <= flat_idx_q + label_t'(1);

      if (ctrl_q == READY && bus.table_release) begin
        max_label_q <= BG_LABEL;
        overflow_q  <= 1'b0;
      end

      resolved_valid_q <= lookup_hit;
      if (lookup_hit) resolved_label_q <= parent[bus.lookup_label];
    end
  end

  assign bus.busy           = in_collect ? fifo_full : 1'b1;
  assign bus.table_ready    = (ctrl_q == READY);
  assign bus.resolved_valid = resolved_valid_q;
  assign bus.resolved_label = resolved_label_q;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_label_equiv_ctrl.sv
// Randomized scoreboard bench for label_equiv_ctrl; the reference keeps each
// label's component as the minimum label reachable through accepted merges.
module tb_label_equiv_ctrl;
  import label_pkg::*;

  typedef struct {
    int a;
    int b;
  } pair_t;

  localparam int TB_DEPTH = DEFAULT_MERGE_DEPTH;

  logic  clk = 1'b0;
  logic  rst_n;
  int    tests_run = 0;
  int    tests_failed = 0;
  int    comp [TABLE_SIZE];
  int    exp_q [$];
  pair_t dir_q [$];
  bit    exp_overflow;

  label_equiv_ctrl_if bus ();

  label_equiv_ctrl #(.MERGE_DEPTH(TB_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.new_label_valid = 1'b0;
    bus.new_label_value = '0;
    bus.merge_valid     = 1'b0;
    bus.merge_a         = '0;
    bus.merge_b         = '0;
    bus.frame_end       = 1'b0;
    bus.lookup_valid    = 1'b0;
    bus.lookup_label    = '0;
    bus.table_release   = 1'b0;
  endtask

  task automatic add_merge(input int a, input int b);
    pair_t p;
    p.a = a;
    p.b = b;
    dir_q.push_back(p);
  endtask

  // Union of two components: everything takes the smaller component id.
  function automatic void model_merge(input int a, input int b);
    int ma, mb, m;
    if (a == b || a == 0 || b == 0) return;
    ma = comp[a];
    mb = comp[b];
    m  = (ma < mb) ? ma : mb;
    for (int x = 1; x < TABLE_SIZE; x++)
      if (comp[x] == ma || comp[x] == mb) comp[x] = m;
  endfunction

  task automatic issue_merge(input int a, input int b);
    bus.merge_valid = 1'b1;
    bus.merge_a     = label_t'(a);
    bus.merge_b     = label_t'(b);
    model_merge(a, b);
  endtask

  // Scoreboard monitor: every resolved output must match the oldest expectation.
  always @(negedge clk) begin
    int e;
    if (rst_n === 1'b1 && bus.resolved_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resolve", int'(bus.resolved_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("resolved_label", int'(bus.resolved_label), e);
      end
    end
  end

  task automatic collect_frame(input int n, input int n_rand, input bit settle,
                               input bit zero_lbl, output bit saw_busy);
    int    next_lbl, alloc, stalls, left_rand, a, b, t;
    bit    need_zero, fe_sent;
    pair_t m;
    saw_busy     = 1'b0;
    next_lbl     = 1;
    stalls       = 0;
    left_rand    = n_rand;
    need_zero    = zero_lbl;
    fe_sent      = 1'b0;
    exp_overflow = zero_lbl;
    for (int x = 0; x < TABLE_SIZE; x++) comp[x] = x;
    while (next_lbl <= n || dir_q.size() > 0 || left_rand > 0 || need_zero) begin
      drive_idle();
      bus.lookup_valid = 1'($urandom_range(0, 1));
      bus.lookup_label = label_t'($urandom);
      if (bus.busy) begin
        if (dir_q.size() > 0) saw_busy = 1'b1;
        stalls++;
        if (stalls > 2000) begin
          check("stall_bound", stalls, 0);
          dir_q.delete();
          left_rand = 0;
          next_lbl  = n + 1;
          need_zero = 1'b0;
        end
        step();
        continue;
      end
      alloc = next_lbl - 1;
      if (need_zero) begin
        bus.new_label_valid = 1'b1;
        bus.new_label_value = BG_LABEL;
        need_zero = 1'b0;
      end else if (next_lbl <= n && $urandom_range(0, 3) != 0) begin
        bus.new_label_valid = 1'b1;
        bus.new_label_value = label_t'(next_lbl);
        next_lbl++;
      end
      if (alloc == n && dir_q.size() > 0) begin
        m = dir_q.pop_front();
        issue_merge(m.a, m.b);
      end else if (left_rand > 0 && alloc >= 1 && $urandom_range(0, 1) == 1) begin
        t = $urandom_range(0, 9);
        a = $urandom_range(1, alloc);
        b = $urandom_range(1, alloc);
        if (t == 0) b = a;
        else if (t == 1) a = 0;
        else if (a > b) begin t = a; a = b; b = t; end
        issue_merge(a, b);
        left_rand--;
      end
      if (!settle && next_lbl > n && dir_q.size() == 0 && left_rand == 0 && !need_zero) begin
        bus.frame_end = 1'b1;
        fe_sent = 1'b1;
      end
      step();
    end
    drive_idle();
    if (!fe_sent) begin
      if (settle) repeat ((TB_DEPTH + 1) * (2 * n + 4) + 4) step();
      bus.frame_end = 1'b1;
      step();
      drive_idle();
    end
  endtask

  task automatic serve_frame(input int n, input bit settle);
    int cyc, t, j;
    int look [$];
    @(negedge clk);
    check("busy_after_frame_end", bus.busy, 1);
    check("ready_low_after_frame_end", bus.table_ready, 0);
    cyc = 0;
    while (!bus.table_ready && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!bus.table_ready) begin
      check("ready_timeout", bus.table_ready, 1);
      return;
    end
    if (settle) check("flatten_cycles", cyc, n + 1);
    check("busy_in_ready", bus.busy, 1);
    check("overflow_flag", bus.overflow, int'(exp_overflow));
    for (int x = 0; x <= n; x++) look.push_back(x);
    for (int x = look.size() - 1; x > 0; x--) begin
      j = $urandom_range(0, x);
      t = look[x];
      look[x] = look[j];
      look[j] = t;
    end
    step();
    foreach (look[k]) begin
      if ($urandom_range(0, 3) == 0) begin
        drive_idle();
        step();
      end
      bus.lookup_valid = 1'b1;
      bus.lookup_label = label_t'(look[k]);
      exp_q.push_back(comp[look[k]]);
      step();
    end
    drive_idle();
    step();
    step();
    check("lookups_drained", exp_q.size(), 0);
    bus.table_release = 1'b1;
    step();
    drive_idle();
    @(negedge clk);
    check("ready_after_release", bus.table_ready, 0);
    check("overflow_after_release", bus.overflow, 0);
    check("busy_after_release", bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d tests so far", tests_run);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit sb, settle, zero;
    int n;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_table_ready", bus.table_ready, 0);
    check("reset_resolved_valid", bus.resolved_valid, 0);
    check("reset_resolved_label", bus.resolved_label, 0);
    check("reset_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    step();

    // Three singleton labels.
    collect_frame(3, 0, 1'b1, 1'b0, sb);
    serve_frame(3, 1'b1);

    // Chain 3->2->1.
    add_merge(2, 3);
    add_merge(1, 2);
    collect_frame(3, 0, 1'b1, 1'b0, sb);
    serve_frame(3, 1'b1);

    // Root of 4 is 3 by the time (2,4) is processed.
    add_merge(3, 4);
    add_merge(1, 2);
    add_merge(2, 4);
    collect_frame(4, 0, 1'b1, 1'b0, sb);
    serve_frame(4, 1'b1);

    // Six back-to-back merges must back up the four-entry FIFO.
    add_merge(1, 2);
    add_merge(3, 4);
    add_merge(5, 6);
    add_merge(7, 8);
    add_merge(2, 4);
    add_merge(6, 8);
    collect_frame(8, 0, 1'b1, 1'b0, sb);
    check("busy_when_fifo_full", int'(sb), 1);
    serve_frame(8, 1'b1);

    // Label space exhaustion.
    collect_frame(3, 0, 1'b1, 1'b1, sb);
    serve_frame(3, 1'b1);

    // Empty frame goes straight to READY.
    collect_frame(0, 0, 1'b1, 1'b0, sb);
    serve_frame(0, 1'b1);

    // Asynchronous reset in the middle of FLATTEN.
    collect_frame(40, 0, 1'b1, 1'b0, sb);
    repeat (5) step();
    check("busy_in_flatten", bus.busy, 1);
    bus.lookup_valid = 1'b1;
    bus.lookup_label = label_t'(7);
    rst_n = 1'b0;
    #1;
    check("midreset_table_ready", bus.table_ready, 0);
    check("midreset_busy", bus.busy, 0);
    check("midreset_resolved_valid", bus.resolved_valid, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_reset_table_ready", bus.table_ready, 0);
    check("post_reset_overflow", bus.overflow, 0);
    check("post_reset_busy", bus.busy, 0);
    drive_idle();
    step();

    // Randomized frames against the reference model.
    for (int f = 0; f < 15; f++) begin
      n      = $urandom_range(2, 24);
      settle = 1'($urandom_range(0, 1));
      zero   = ($urandom_range(0, 5) == 0);
      collect_frame(n, $urandom_range(0, 2 * n), settle, zero, sb);
      serve_frame(n, settle);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
